amber128_dmem_arb: RTL and testbench
====================================

AMBER128_DMEM_ARB -- requirements
Module: amber128_dmem_arb

Interface
REQ-001 SHALL have parameter XLEN, default 128, data width of all wdata/rdata buses.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of BUSY cycles before an aborted access; 0 disables the timeout.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports m0_req_i/m1_req_i  in  1  requester 0 (core) / requester 1 (debug) access request.
REQ-006 SHALL have ports m0_we_i/m1_we_i  in  1  write enable.
REQ-007 SHALL have ports m0_addr_i/m1_addr_i  in  64  byte address.
REQ-008 SHALL have ports m0_wdata_i/m1_wdata_i  in  XLEN  write data.
REQ-009 SHALL have ports m0_ready_o/m1_ready_o  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_rdata_o/m1_rdata_o  out  XLEN  read data, valid with ready.
REQ-011 SHALL have ports m0_trap_o/m1_trap_o  out  1  access fault, valid with ready.
REQ-012 SHALL have ports s_req_o  out  1, s_we_o  out  1, s_addr_o  out  64, s_wdata_o  out  XLEN  downstream dmem command.
REQ-013 SHALL have ports s_rdata_i  in  XLEN, s_ready_i  in  1, s_trap_i  in  1  downstream response.
REQ-014 SHALL have port grant_o  out  1  index of the owning requester, valid while busy_o.
REQ-015 SHALL have port busy_o  out  1  high in BUSY.
REQ-016 SHALL have port timeout_cnt_o  out  8  saturating count of timed-out accesses.

Function
REQ-017 SHALL implement FSM states IDLE and BUSY.
REQ-018 In IDLE, if at least one mN_req_i is high, SHALL register the winner's we/addr/wdata, set grant, and enter BUSY next cycle.
REQ-019 Arbitration SHALL be round-robin: a single requester always wins; with both high, the winner is the port not equal to last_q. last_q updates to the winner on each grant.
REQ-020 In BUSY, s_req_o SHALL be 1 and s_we_o/s_addr_o/s_wdata_o SHALL equal the registered command, stable for the whole state.
REQ-021 On s_ready_i=1 in BUSY: granted mN_ready_o SHALL pulse combinationally that cycle, with mN_rdata_o=s_rdata_i and mN_trap_o=s_trap_i; FSM returns to IDLE next cycle.
REQ-022 Non-granted ready/trap SHALL be 0; all mN_rdata_o SHALL be 0 when their ready is 0.
REQ-023 Grant-to-s_req_o latency SHALL be 1 cycle. The minimum spacing between successive grants SHALL be 1 IDLE cycle.
REQ-024 A requester SHALL hold req and command stable until its ready pulse. A req still high in the IDLE cycle after ready SHALL be treated as a new access.
REQ-025 A BUSY-cycle counter SHALL clear on grant. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with s_ready_i=0: pulse granted ready with trap=1 and rdata=0, deassert s_req_o next cycle, return to IDLE, increment timeout_cnt_o (saturate at 255).
REQ-026 s_ready_i and timeout in the same cycle: the response SHALL win, with no trap forced and no count increment.
REQ-027 s_ready_i while IDLE SHALL be ignored: no ready pulses and no state change.
REQ-028 Requester input changes during BUSY SHALL NOT affect s_* outputs.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, last_q=1 (port 0 wins first contention), counter=0, timeout_cnt_o=0, and all outputs 0, including mid-transaction; no ready pulse is generated for an aborted access.

Verification
REQ-030 m0 read addr 0x100 only; s_ready_i 3 cycles after s_req_o with rdata=0xA5 -> m0_ready_o single pulse, m0_rdata_o=0xA5, m1_ready_o=0, grant_o=0.
REQ-031 m0 and m1 request simultaneously from reset, both held -> grants alternate 0,1,0,1; each s_req_o period carries the correct addr/we/wdata.
REQ-032 TIMEOUT_CYCLES=4, m1 write, s_ready_i never asserted -> m1_ready_o pulse with m1_trap_o=1 after 4 BUSY cycles, s_req_o low next cycle, timeout_cnt_o=1.
REQ-033 s_ready_i coincident with timeout cycle, s_trap_i=0 -> trap=0, rdata passed through, timeout_cnt_o unchanged; s_ready_i pulse in IDLE -> no ready pulse.
REQ-034 rst_ni low mid-BUSY -> s_req_o and busy_o 0 immediately; after release, port 0 wins a contention.
REQ-035 260 forced timeouts -> timeout_cnt_o saturates at 255.

Source files
------------

// File: rtl/amber128_dmem_arb.sv
// Two-requester round-robin arbiter in front of a single data-memory port.
// Owns one access at a time and aborts with a trap if the memory stalls too long.
module amber128_dmem_arb #(
  parameter int unsigned XLEN           = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [63:0]     m0_addr_i,
  input  logic [XLEN-1:0] m0_wdata_i,
  output logic            m0_ready_o,
  output logic [XLEN-1:0] m0_rdata_o,
  output logic            m0_trap_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [63:0]     m1_addr_i,
  input  logic [XLEN-1:0] m1_wdata_i,
  output logic            m1_ready_o,
  output logic [XLEN-1:0] m1_rdata_o,
  output logic            m1_trap_o,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [63:0]     s_addr_o,
  output logic [XLEN-1:0] s_wdata_o,
  input  logic [XLEN-1:0] s_rdata_i,
  input  logic            s_ready_i,
  input  logic            s_trap_i,
  output logic            grant_o,
  output logic            busy_o,
  output logic [7:0]      timeout_cnt_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              last_q, grant_q;
  logic              we_q;
  logic [63:0]       addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [7:0]        timeout_cnt_q;

  logic any_req, winner, grant_now, busy, timeout_hit, done;

  always_comb begin
    any_req   = m0_req_i | m1_req_i;
    // Contention goes to the port that did not win last; otherwise the lone requester wins.
    winner    = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
    busy      = (state_q == BUSY);
    grant_now = (state_q == IDLE) & any_req;
    // A memory response in the timeout cycle takes precedence over the abort.
    timeout_hit = busy & (TIMEOUT_CYCLES != 0) & (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES)) & ~s_ready_i;
    done      = busy & (s_ready_i | timeout_hit);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (done)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      grant_q       <= 1'b0;
      busy_cnt_q    <= '0;
      timeout_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        last_q     <= winner;
        grant_q    <= winner;
        busy_cnt_q <= '0;
      end else if (busy) begin
        busy_cnt_q <= busy_cnt_q + CNT_W'(1);
      end
      if (timeout_hit && timeout_cnt_q != 8'hFF)
        timeout_cnt_q <= timeout_cnt_q + 8'd1;
    end
  end

  // Command capture needs no reset: every use is gated by BUSY.
  always_ff @(posedge clk_i) begin
    if (grant_now) begin
      we_q    <= winner ? m1_we_i    : m0_we_i;
      addr_q  <= winner ? m1_addr_i  : m0_addr_i;
      wdata_q <= winner ? m1_wdata_i : m0_wdata_i;
    end
  end

  always_comb begin
    busy_o        = busy;
    grant_o       = grant_q;
    timeout_cnt_o = timeout_cnt_q;
    s_req_o       = busy;
    s_we_o        = busy & we_q;
    s_addr_o      = busy ? addr_q  : '0;
    s_wdata_o     = busy ? wdata_q : '0;
    m0_ready_o    = done & ~grant_q;
    m1_ready_o    = done &  grant_q;
    m0_trap_o     = m0_ready_o & (s_ready_i ? s_trap_i : 1'b1);
    m1_trap_o     = m1_ready_o & (s_ready_i ? s_trap_i : 1'b1);
    m0_rdata_o    = (m0_ready_o & s_ready_i) ? s_rdata_i : '0;
    m1_rdata_o    = (m1_ready_o & s_ready_i) ? s_rdata_i : '0;
  end

endmodule

// File: tb/tb_amber128_dmem_arb.sv
// Directed bench for amber128_dmem_arb with a short timeout of 4 BUSY cycles.
module tb_amber128_dmem_arb;

  localparam int XLEN = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_req, m0_we, m1_req, m1_we;
  logic [63:0]     m0_addr, m1_addr;
  logic [XLEN-1:0] m0_wdata, m1_wdata;
  logic            m0_ready, m0_trap, m1_ready, m1_trap;
  logic [XLEN-1:0] m0_rdata, m1_rdata;
  logic            s_req, s_we, s_ready, s_trap;
  logic [63:0]     s_addr;
  logic [XLEN-1:0] s_wdata, s_rdata;
  logic            grant, busy;
  logic [7:0]      timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amber128_dmem_arb #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata), .m0_trap_o(m0_trap),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata), .m1_trap_o(m1_trap),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .s_ready_i(s_ready), .s_trap_i(s_trap),
    .grant_o(grant), .busy_o(busy), .timeout_cnt_o(timeout_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ready = 0; s_trap = 0; s_rdata = '0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_sreq", s_req, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_tocnt", timeout_cnt, 8'd0);
    chk("rst_m0rdy", m0_ready, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // Single m0 read, response 3 cycles into BUSY
    m0_req = 1; m0_we = 0; m0_addr = 64'h100;
    tick();
    chk("r0_busy", busy, 1'b1);
    chk("r0_sreq", s_req, 1'b1);
    chk("r0_saddr", s_addr, 64'h100);
    chk("r0_swe", s_we, 1'b0);
    chk("r0_grant", grant, 1'b0);
    m0_addr = 64'hDEAD; m0_we = 1;
    tick(); tick();
    chk("r0_m0rdy_wait", m0_ready, 1'b0);
    chk("r0_saddr_hold", s_addr, 64'h100);
    chk("r0_swe_hold", s_we, 1'b0);
    tick();
    s_ready = 1; s_rdata = 128'hA5; #1;
    chk("r0_m0rdy", m0_ready, 1'b1);
    chk("r0_m0rdata", m0_rdata, 128'hA5);
    chk("r0_m0trap", m0_trap, 1'b0);
    chk("r0_m1rdy", m1_ready, 1'b0);
    chk("r0_m1rdata", m1_rdata, 128'h0);
    m0_req = 0;
    tick();
    s_ready = 0; #1;
    chk("r0_idle", busy, 1'b0);
    chk("r0_m0rdy_off", m0_ready, 1'b0);
    chk("r0_m0rdata_off", m0_rdata, 128'h0);

    // Contention from reset: grants alternate 0,1,0,1
    rst_n = 0; #2; rst_n = 1;
    m0_req = 1; m0_we = 1; m0_addr = 64'h200; m0_wdata = 128'h11;
    m1_req = 1; m1_we = 0; m1_addr = 64'h300; m1_wdata = 128'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", grant, (i % 2 == 1));
      chk("rr_saddr", s_addr, (i % 2 == 1) ? 64'h300 : 64'h200);
      chk("rr_swe", s_we, (i % 2 == 0));
      chk("rr_swdata", s_wdata, (i % 2 == 1) ? 128'h22 : 128'h11);
      s_ready = 1; s_trap = (i == 1); s_rdata = 128'h40 + i; #1;
      chk("rr_m0rdy", m0_ready, (i % 2 == 0));
      chk("rr_m1rdy", m1_ready, (i % 2 == 1));
      chk("rr_m1trap", m1_trap, (i == 1));
      chk("rr_m1rdata", m1_rdata, (i % 2 == 1) ? 128'h40 + i : 128'h0);
      tick();
      s_ready = 0; s_trap = 0; #1;
      chk("rr_gap_idle", busy, 1'b0);
    end
    m0_req = 0; m1_req = 0;

    // m1 write that times out after 4 BUSY cycles
    m1_req = 1; m1_we = 1; m1_addr = 64'h400; m1_wdata = 128'h33;
    tick();
    chk("to_grant", grant, 1'b1);
    tick(); tick(); tick();
    chk("to_m1rdy_early", m1_ready, 1'b0);
    tick();
    chk("to_m1rdy", m1_ready, 1'b1);
    chk("to_m1trap", m1_trap, 1'b1);
    chk("to_m1rdata", m1_rdata, 128'h0);
    chk("to_m0rdy", m0_ready, 1'b0);
    m1_req = 0;
    tick();
    chk("to_sreq_low", s_req, 1'b0);
    chk("to_tocnt", timeout_cnt, 8'd1);

    // Response coincident with timeout cycle wins
    m0_req = 1; m0_we = 0; m0_addr = 64'h500;
    tick();
    tick(); tick(); tick(); tick();
    s_ready = 1; s_trap = 0; s_rdata = 128'h5A; #1;
    chk("co_m0rdy", m0_ready, 1'b1);
    chk("co_m0trap", m0_trap, 1'b0);
    chk("co_m0rdata", m0_rdata, 128'h5A);
    m0_req = 0;
    tick();
    s_ready = 0; #1;
    chk("co_tocnt", timeout_cnt, 8'd1);
    chk("co_idle", busy, 1'b0);
    s_ready = 1; #1;
    chk("idle_m0rdy", m0_ready, 1'b0);
    chk("idle_m1rdy", m1_ready, 1'b0);
    tick();
    chk("idle_stay", busy, 1'b0);
    s_ready = 0;

    // Reset mid-BUSY, then port 0 wins contention
    m1_req = 1; m1_we = 0; m1_addr = 64'h700;
    tick();
    chk("mr_busy", busy, 1'b1);
    rst_n = 0; #1;
    chk("mr_sreq", s_req, 1'b0);
    chk("mr_busy0", busy, 1'b0);
    chk("mr_m1rdy", m1_ready, 1'b0);
    chk("mr_tocnt", timeout_cnt, 8'd0);
    m0_req = 1; m0_we = 0; m0_addr = 64'h600;
    @(negedge clk); rst_n = 1;
    tick();
    chk("mr_grant", grant, 1'b0);
    chk("mr_saddr", s_addr, 64'h600);
    s_ready = 1; s_rdata = 128'h1; #1;
    m0_req = 0; m1_req = 0;
    tick();
    s_ready = 0;

    // 260 forced timeouts saturate the counter
    for (int i = 0; i < 260; i++) begin
      m0_req = 1;
      tick();
      tick(); tick(); tick(); tick();
      if (i == 259) chk("sat_m0trap", m0_trap, 1'b1);
      m0_req = 0;
      tick();
      if (i == 253) chk("sat_tocnt_254", timeout_cnt, 8'd254);
      if (i == 254) chk("sat_tocnt_255", timeout_cnt, 8'd255);
    end
    chk("sat_tocnt_final", timeout_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
